// File: rtl/param_sync_counter_if.sv
// Control/status bundle for param_sync_counter: count controls in, count state out.
interface param_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  // Controller side: drives the controls, observes the count.
  modport master (
    output enable,
    output up_down,
    output load,
    output load_value,
    input  q,
    input  tc,
    input  wrapped
  );

  // Counter side: observes the controls, drives the count.
  modport slave (
    input  enable,
    input  up_down,
    input  load,
    input  load_value,
    output q,
    output tc,
    output wrapped
  );
endinterface

// File: rtl/param_sync_counter.sv
// Synchronous mod-MODULUS up/down counter, falling-edge clocked, with parallel
// load (clamped to the range), wrap or saturate at the range ends, a
// combinational terminal count for cascading and a registered wrap pulse.
module param_sync_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 16,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic                 clock_n,
  input logic                 reset,
  param_sync_counter_if.slave bus
);

  // One extra bit of headroom so q+1 at MODULUS = 2**WIDTH is still visible.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q  = WIDTH'(0);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q_r;
  logic             wrapped_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrapped_next_s;
  logic [WIDTH:0]   q_inc_s;
  logic [WIDTH:0]   q_dec_s;
  logic             at_top_s;
  logic             at_zero_s;
  logic             tc_s;

  // Out-of-range load values are clamped to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if ({1'b0, value} >= MOD_EXT) begin
      result = MAX_Q;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Range-end detection from the widened arithmetic: the increment reaching
  // MODULUS marks the top, the decrement borrowing out marks zero.
  assign q_inc_s   = {1'b0, q_r} + ONE_EXT;
  assign q_dec_s   = {1'b0, q_r} - ONE_EXT;
  assign at_top_s  = (q_inc_s >= MOD_EXT);
  assign at_zero_s = q_dec_s[WIDTH];

  // Terminal count: ignores SATURATE and load so a following stage sees a
  // pure "this stage rolls over on this edge if counting" flag.
  assign tc_s = bus.enable & ((bus.up_down & at_top_s) | (~bus.up_down & at_zero_s));

  // Next-state selection with priority load > enable > hold.
  always_comb begin
    q_next_s       = q_r;
    wrapped_next_s = 1'b0;
    if (bus.load) begin
      q_next_s       = clamp_load(bus.load_value);
      wrapped_next_s = 1'b0;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (at_top_s) begin
          if (SATURATE) begin
            q_next_s       = q_r;
            wrapped_next_s = 1'b0;
          end else begin
            q_next_s       = ZERO_Q;
            wrapped_next_s = 1'b1;
          end
        end else begin
          q_next_s       = q_inc_s[WIDTH-1:0];
          wrapped_next_s = 1'b0;
        end
      end else begin
        if (at_zero_s) begin
          if (SATURATE) begin
            q_next_s       = q_r;
            wrapped_next_s = 1'b0;
          end else begin
            q_next_s       = MAX_Q;
            wrapped_next_s = 1'b1;
          end
        end else begin
          q_next_s       = q_dec_s[WIDTH-1:0];
          wrapped_next_s = 1'b0;
        end
      end
    end else begin
      q_next_s       = q_r;
      wrapped_next_s = 1'b0;
    end
  end

  // Count and wrap-pulse registers; reset acts immediately, clearing any pending pulse.
  always_ff @(negedge clock_n or posedge reset) begin
    if (reset) begin
      q_r       <= RST_Q;
      wrapped_r <= 1'b0;
    end else begin
      q_r       <= q_next_s;
      wrapped_r <= wrapped_next_s;
    end
  end

  assign bus.q       = q_r;
  assign bus.wrapped = wrapped_r;
  assign bus.tc      = tc_s;

endmodule

// File: tb/tb_param_sync_counter.sv
// Directed, table-driven bench for param_sync_counter: default wrap counter,
// MODULUS=10 wrap and saturate variants, and a two-stage cascade.
module tb_param_sync_counter;

  logic       clock_n;
  logic       reset;
  logic       en, ud, ld;
  logic [3:0] lv;
  logic       en_c;

  int n_tests;
  int n_fail;

  param_sync_counter_if #(.WIDTH(4)) def_if ();
  param_sync_counter_if #(.WIDTH(4)) m10_if ();
  param_sync_counter_if #(.WIDTH(4)) sat_if ();
  param_sync_counter_if #(.WIDTH(4)) lo_if ();
  param_sync_counter_if #(.WIDTH(4)) hi_if ();

  assign def_if.enable = en;   assign def_if.up_down = ud;
  assign def_if.load   = ld;   assign def_if.load_value = lv;
  assign m10_if.enable = en;   assign m10_if.up_down = ud;
  assign m10_if.load   = ld;   assign m10_if.load_value = lv;
  assign sat_if.enable = en;   assign sat_if.up_down = ud;
  assign sat_if.load   = ld;   assign sat_if.load_value = lv;
  assign lo_if.enable  = en_c; assign lo_if.up_down = 1'b1;
  assign lo_if.load    = 1'b0; assign lo_if.load_value = 4'd0;
  assign hi_if.enable  = lo_if.tc; assign hi_if.up_down = 1'b1;
  assign hi_if.load    = 1'b0; assign hi_if.load_value = 4'd0;

  param_sync_counter u_def (.clock_n(clock_n), .reset(reset), .bus(def_if));
  param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VALUE(0))
    u_m10 (.clock_n(clock_n), .reset(reset), .bus(m10_if));
  param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VALUE(0))
    u_sat (.clock_n(clock_n), .reset(reset), .bus(sat_if));
  param_sync_counter u_lo (.clock_n(clock_n), .reset(reset), .bus(lo_if));
  param_sync_counter u_hi (.clock_n(clock_n), .reset(reset), .bus(hi_if));

  // Clock starts low, 10 ns period; falling edges at 10, 20, 30 ...
  initial begin
    clock_n = 1'b0;
    forever #5 clock_n = ~clock_n;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       en, ud, ld;
    logic [3:0] lv;
    logic       tc_m, tc_s;   // before the edge
    logic [3:0] q_m;  logic w_m;  // after the edge, MODULUS=10 wrap
    logic [3:0] q_s;  logic w_s;  // after the edge, MODULUS=10 saturate
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic e, logic u, logic l, logic [3:0] v,
                              logic tm, logic ts, logic [3:0] qm, logic wm,
                              logic [3:0] qs, logic ws);
    vec_t r;
    r.en = e; r.ud = u; r.ld = l; r.lv = v; r.tc_m = tm; r.tc_s = ts;
    r.q_m = qm; r.w_m = wm; r.q_s = qs; r.w_s = ws;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] v);
    en = e; ud = u; ld = l; lv = v;
  endtask

  task automatic edge_wait();
    @(negedge clock_n);
    #1;
  endtask

  initial begin
    int exp_cnt;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    en_c  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd0);

    // Vectors continue from the state test 1 leaves: MODULUS=10 at 6, saturate at 9.
    tbl[0] = mk(1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 9; k++)
      tbl[k+1] = mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0,
                    4'(k+1), 1'b0, 4'(k+1), 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b1, 4'd9, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 4'd1, 1'b0, 4'd9, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd9, 1'b0, 4'd1, 1'b0);
    tbl[20] = mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd9, 1'b0, 4'd1, 1'b0);
    tbl[21] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    tbl[22] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd1, 1'b0, 4'd3, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0);

    // Test 1: default counter, reset 0-15 ns, then count up 16 edges.
    #1;
    chk("rst_q", int'(def_if.q), 0);
    chk("rst_wrapped", int'(def_if.wrapped), 0);
    chk("rst_tc", int'(def_if.tc), 0);
    #14;
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      edge_wait();
      chk("def_q", int'(def_if.q), i % 16);
      chk("def_wrapped", int'(def_if.wrapped), (i == 16) ? 1 : 0);
      chk("def_tc", int'(def_if.tc), ((i % 16) == 15) ? 1 : 0);
    end

    // Tests 2, 3, 5: table of wrap/saturate/load/direction vectors.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv);
      #1;
      chk("tbl_tc_m10", int'(m10_if.tc), int'(tbl[i].tc_m));
      chk("tbl_tc_sat", int'(sat_if.tc), int'(tbl[i].tc_s));
      edge_wait();
      chk("tbl_q_m10", int'(m10_if.q), int'(tbl[i].q_m));
      chk("tbl_w_m10", int'(m10_if.wrapped), int'(tbl[i].w_m));
      chk("tbl_q_sat", int'(sat_if.q), int'(tbl[i].q_s));
      chk("tbl_w_sat", int'(sat_if.wrapped), int'(tbl[i].w_s));
    end

    // Test 4: asynchronous reset while counting at q=7.
    drive(1'b0, 1'b1, 1'b1, 4'd6);
    edge_wait();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    edge_wait();
    chk("pre_rst_q", int'(m10_if.q), 7);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_q", int'(m10_if.q), 0);
    #10 reset = 1'b0;
    edge_wait();
    chk("post_rst_q", int'(m10_if.q), 1);

    // Reset clears a pending wrap pulse before the next edge.
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    edge_wait();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    edge_wait();
    chk("pulse_set", int'(m10_if.wrapped), 1);
    #1 reset = 1'b1;
    #1;
    chk("pulse_cleared", int'(m10_if.wrapped), 0);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd0);

    // Test 6: two cascaded 4-bit stages, 300 edges from 0.
    chk("chain_start", int'({hi_if.q, lo_if.q}), 0);
    en_c = 1'b1;
    exp_cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      edge_wait();
      exp_cnt = i % 256;
      chk("chain_value", int'({hi_if.q, lo_if.q}), exp_cnt);
      chk("chain_lo_wrap", int'(lo_if.wrapped), ((i % 16) == 0) ? 1 : 0);
    end
    chk("chain_final", int'({hi_if.q, lo_if.q}), 44);
    en_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
